sr_latch_command_sequencer: RTL
===============================

# sr_latch_command_sequencer

Upstream driver for the gated SR latch with enable (NOR-based) in the latch experiment. It takes two raw, bouncing pushbuttons (SET, RESET), synchronises and debounces each one, and turns each debounced press into a latch write. A latch write is a clean, glitch-free set or reset pulse framed by a bounded enable window. The block never presents set=reset=1 to the latch, which is the forbidden NOR-latch input, and it serialises presses that arrive while a write is in progress.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 4: consecutive stable samples needed to accept a button level change; must be ≥2.
- PULSE_CYCLES, default 2: number of cycles enable is high per write; must be ≥1.

Ports:
- clock  in  1  single system clock; all state updates on its rising edge.
- reset_  in  1  asynchronous, active-low reset.
- button_set  in  1  raw active-high SET pushbutton; asynchronous to clock.
- button_reset  in  1  raw active-high RESET pushbutton; asynchronous to clock.
- enable  out  1  latch enable.
- set  out  1  latch set input.
- reset  out  1  latch reset input.
- busy  out  1  high whenever a write sequence is in progress (FSM not in IDLE).
- conflict  out  1  one-cycle pulse when both buttons produce a rising edge in the same cycle.
- dropped  out  1  one-cycle pulse when a pending command is overwritten.

## Operation
Input path, per button:
- Two-flop synchroniser.
- Debouncer: a counter runs while the synchronised value differs from the debounced level and clears when they match. When the counter reaches DEBOUNCE_CYCLES, the debounced level takes the synchronised value and the counter clears.
- Rising-edge detect on the debounced level (debounced AND NOT previous debounced). Releases, i.e. falling edges, produce no command.

Command arbitration:
- Rising edge on exactly one button gives a command, CMD_SET or CMD_RESET.
- Rising edges on both buttons in the same cycle: no command is issued, conflict pulses for 1 cycle, and any existing pending command is left unchanged.
- Command while the FSM is in IDLE with nothing pending: it starts a sequence immediately.
- Command while busy: it is stored in a 1-deep pending slot. If the slot is already full, the newer command replaces the older one and dropped pulses for 1 cycle.

FSM states: IDLE, SETUP, ENABLE, HOLD.
- IDLE → SETUP on a new command, or on a pending command (the slot is consumed). A pending command has priority over a simultaneous new edge; that new edge goes into the slot.
- SETUP → ENABLE after 1 cycle.
- ENABLE → HOLD after PULSE_CYCLES cycles, counted by a pulse counter.
- HOLD → IDLE after 1 cycle.
- The latched command selects the output line: set for CMD_SET, reset for CMD_RESET.

Outputs are registered from the next-state decode:
- SETUP: the selected line is 1; enable is 0.
- ENABLE: the selected line is 1; enable is 1.
- HOLD: the selected line is 1; enable is 0.
- IDLE: all three outputs are 0.
- set and reset are never 1 in the same cycle.
- enable is never 1 unless exactly one of set or reset is 1.

Reset (reset_ low), asynchronous and effective at any point including mid-sequence:
- Outputs: enable=0, set=0, reset=0, busy=0, conflict=0, dropped=0.
- FSM goes to IDLE; the pending slot is emptied.
- Synchronisers, debounced levels and previous debounced levels are set to 0; counters are cleared.

## Timing
- Raw button rises before clock edge 1 and is held high:
  - Synchronised value is 1 after edge 2.
  - Debounced level is 1 after edge 2+DEBOUNCE_CYCLES.
  - set/reset go high at the next edge (3+DEBOUNCE_CYCLES).
  - enable is high for PULSE_CYCLES cycles starting one edge later.
  - After HOLD (1 cycle), all outputs are low.
- One write lasts PULSE_CYCLES+2 cycles of busy.
- A pending command starts SETUP on the edge immediately after HOLD→IDLE, with one IDLE cycle in between; busy is low for that cycle.
- Bounce: any return to the old level before DEBOUNCE_CYCLES stable samples clears the counter. The debounced level does not change.
- A button held indefinitely gives exactly one command.
- Counter widths are $clog2 of the parameter plus 1.

## Test plan
- Reset: hold reset_ low for 3 cycles while toggling the buttons → all outputs 0 throughout. Release reset_, then press SET → first write as below.
- Clean SET press (DEBOUNCE_CYCLES=4, PULSE_CYCLES=2), button rises before edge 1 → set=1 at edges 7–10, enable=1 at edges 8–9, busy=1 at edges 7–10, all outputs 0 at edge 11.
- Bounce: SET toggles every 2 cycles for 10 cycles, then settles high → exactly one write, starting 7 edges after the final rise.
- Both buttons rise in the same cycle → conflict=1 for 1 cycle, no write, set and reset never both 1.
- During a SET write, press RESET then SET (both debounced while busy) → dropped=1 once, then exactly one further write, which is SET, starting one cycle after the first write ends.
- Assert reset_ during the ENABLE state → enable, set and busy go 0 immediately (asynchronous). After release, the block is idle and the interrupted command is not replayed.

Source files
------------

// File: rtl/sr_latch_command_sequencer.sv
// Debounced two-button front end that drives a NOR SR latch with framed, one-hot set/reset
// writes, serialising presses through a single pending slot.
module sr_latch_command_sequencer #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned PULSE_CYCLES    = 2
) (
  input  logic clock,
  input  logic reset_,
  input  logic button_set,
  input  logic button_reset,
  output logic enable,
  output logic set,
  output logic reset,
  output logic busy,
  output logic conflict,
  output logic dropped
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned PwW = $clog2(PULSE_CYCLES) + 1;

  typedef enum logic [1:0] {StIdle, StSetup, StEnable, StHold} state_e;

  // Bit 0 carries the SET button, bit 1 the RESET button.
  logic [1:0]     raw;
  logic [1:0]     sync1_q, sync2_q;
  logic [1:0]     deb_q, deb_prev_q;
  logic [DbW-1:0] db_cnt_q [2];
  logic [1:0]     rise;

  state_e         state_q, state_d;
  logic           cmd_q, cmd_d;
  logic           pend_valid_q, pend_valid_d;
  logic           pend_cmd_q, pend_cmd_d;
  logic [PwW-1:0] pulse_cnt_q, pulse_cnt_d;
  logic           new_valid, new_cmd;
  logic           conflict_d, dropped_d;

  assign raw = {button_reset, button_set};

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DbW'(DEBOUNCE_CYCLES - 1)) begin
          // This sample is the DEBOUNCE_CYCLES-th consecutive differing one.
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise      = deb_q & ~deb_prev_q;
  assign new_valid = rise[0] ^ rise[1];
  assign new_cmd   = rise[0];

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    pend_valid_d = pend_valid_q;
    pend_cmd_d   = pend_cmd_q;
    pulse_cnt_d  = pulse_cnt_q;
    conflict_d   = rise[0] & rise[1];
    dropped_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (pend_valid_q) begin
          // Pending command wins; a simultaneous new edge refills the slot.
          state_d      = StSetup;
          cmd_d        = pend_cmd_q;
          pend_valid_d = new_valid;
          pend_cmd_d   = new_valid ? new_cmd : pend_cmd_q;
        end else if (new_valid) begin
          state_d = StSetup;
          cmd_d   = new_cmd;
        end
      end
      StSetup: begin
        state_d     = StEnable;
        pulse_cnt_d = '0;
      end
      StEnable: begin
        if (pulse_cnt_q == PwW'(PULSE_CYCLES - 1)) begin
          state_d = StHold;
        end else begin
          pulse_cnt_d = pulse_cnt_q + 1'b1;
        end
      end
      StHold: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (state_q != StIdle && new_valid) begin
      dropped_d    = pend_valid_q;
      pend_valid_d = 1'b1;
      pend_cmd_d   = new_cmd;
    end
  end

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state_q      <= StIdle;
      cmd_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_cmd_q   <= 1'b0;
      pulse_cnt_q  <= '0;
      enable       <= 1'b0;
      set          <= 1'b0;
      reset        <= 1'b0;
      busy         <= 1'b0;
      conflict     <= 1'b0;
      dropped      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      pend_valid_q <= pend_valid_d;
      pend_cmd_q   <= pend_cmd_d;
      pulse_cnt_q  <= pulse_cnt_d;
      // Outputs decode the next state so they align with it; set/reset are one-hot by cmd_d.
      enable       <= (state_d == StEnable);
      set          <= (state_d != StIdle) && cmd_d;
      reset        <= (state_d != StIdle) && !cmd_d;
      busy         <= (state_d != StIdle);
      conflict     <= conflict_d;
      dropped      <= dropped_d;
    end
  end

endmodule
